// File: rtl/branch_resolve_unit_pkg.sv
// Shared rv32 definitions: branch opcodes, BHT reset encoding, PC step.
package rv32_pkg;

   typedef enum logic [2:0] {
      B_NONE = 3'd0,
      B_BEQ  = 3'd1,
      B_BNE  = 3'd2,
      B_BLT  = 3'd3,
      B_BGE  = 3'd4,
      B_BLTU = 3'd5,
      B_BGEU = 3'd6
   } b_t;

   // Weakly not-taken: the largest value whose MSB is still 0.
   function automatic int bht_init(input int ctr_w);
      return (1 << (ctr_w - 1)) - 1;
   endfunction

   localparam int BHT_INIT = bht_init(2);
   localparam int PC_STEP  = 4;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Handshake, operand, lookup and result bundle of the branch resolution stage.
interface branch_resolve_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       branch_type;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  imm;
   logic             pred_taken;
   logic             flush;
   logic [XLEN-1:0]  lookup_pc;
   logic             lookup_taken;
   logic             out_valid;
   logic             out_ready;
   logic             taken;
   logic [XLEN-1:0]  target;
   logic             mispredict;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output in_valid, branch_type, rs1_data, rs2_data, pc, imm, pred_taken,
             flush, lookup_pc, out_ready,
      input  in_ready, lookup_taken, out_valid, taken, target, mispredict,
             redirect_pc, mispredict_cnt
   );

   modport slave (
      input  in_valid, branch_type, rs1_data, rs2_data, pc, imm, pred_taken,
             flush, lookup_pc, out_ready,
      output in_ready, lookup_taken, out_valid, taken, target, mispredict,
             redirect_pc, mispredict_cnt
   );
endinterface

// File: rtl/branch_resolve_unit_bht.sv
// Bimodal history table: saturating counters, one update port, one combinational read port.
module bht
   import rv32_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CTR_W = 2,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             we_i,
   input  logic             taken_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o
);
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(bht_init(CTR_W));
   localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

   logic [CTR_W-1:0] ctr_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
      end else if (we_i) begin
         if (taken_i) begin
            if (ctr_q[wr_idx_i] != CTR_MAX) ctr_q[wr_idx_i] <= ctr_q[wr_idx_i] + CTR_W'(1);
         end else begin
            if (ctr_q[wr_idx_i] != '0) ctr_q[wr_idx_i] <= ctr_q[wr_idx_i] - CTR_W'(1);
         end
      end
   end

   // No write bypass: fetch sees an update one cycle after it happens.
   assign rd_taken_o = ctr_q[rd_idx_i][CTR_W-1];
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: compares operands, computes target/redirect, checks prediction, trains BHT.
module branch_resolve_unit
   import rv32_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 16,
   parameter int CTR_W     = 2,
   parameter int CNT_W     = 32
) (
   input logic clk,
   input logic rst,
   branch_resolve_unit_if.slave bus
);
   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic            accept, deliver, is_branch, taken_d, mispredict_d;
   logic            eq, lt_s, lt_u;
   logic [XLEN-1:0] target_d, redirect_d;

   logic             out_valid_q, taken_q, mispredict_q;
   logic [XLEN-1:0]  target_q, redirect_q;
   logic [CNT_W-1:0] cnt_q;
   logic             unused_lookup;

   assign eq   = bus.rs1_data == bus.rs2_data;
   assign lt_s = $signed(bus.rs1_data) < $signed(bus.rs2_data);
   assign lt_u = bus.rs1_data < bus.rs2_data;

   always_comb begin
      is_branch = 1'b1;
      taken_d   = 1'b0;
      case (b_t'(bus.branch_type))
         B_BEQ:   taken_d = eq;
         B_BNE:   taken_d = !eq;
         B_BLT:   taken_d = lt_s;
         B_BGE:   taken_d = !lt_s;
         B_BLTU:  taken_d = lt_u;
         B_BGEU:  taken_d = !lt_u;
         default: is_branch = 1'b0;
      endcase
   end

   assign mispredict_d = is_branch & (taken_d ^ bus.pred_taken);
   assign target_d     = bus.pc + bus.imm;
   assign redirect_d   = taken_d ? target_d : bus.pc + XLEN'(PC_STEP);

   assign bus.in_ready = !out_valid_q | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;
   // A flushed op still trains the BHT but never reaches the output register.
   assign deliver      = accept & !bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         taken_q      <= 1'b0;
         mispredict_q <= 1'b0;
         target_q     <= '0;
         redirect_q   <= '0;
         cnt_q        <= '0;
      end else begin
         if (deliver) begin
            out_valid_q  <= 1'b1;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            target_q     <= target_d;
            redirect_q   <= redirect_d;
         end else if (bus.flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (out_valid_q && bus.out_ready && mispredict_q && !(&cnt_q))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   bht #(.DEPTH(BHT_DEPTH), .CTR_W(CTR_W)) u_bht (
      .clk        (clk),
      .rst        (rst),
      .wr_idx_i   (bus.pc[IDX_W+1:2]),
      .we_i       (accept & is_branch),
      .taken_i    (taken_d),
      .rd_idx_i   (bus.lookup_pc[IDX_W+1:2]),
      .rd_taken_o (bus.lookup_taken)
   );

   assign unused_lookup = ^bus.lookup_pc;

   assign bus.out_valid      = out_valid_q;
   assign bus.taken          = taken_q;
   assign bus.mispredict     = mispredict_q;
   assign bus.target         = target_q;
   assign bus.redirect_pc    = redirect_q;
   assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bif ();

   branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16), .CTR_W(2), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i, input logic pr);
      bif.in_valid    = 1'b1;
      bif.branch_type = t;
      bif.rs1_data    = a;
      bif.rs2_data    = b;
      bif.pc          = p;
      bif.imm         = i;
      bif.pred_taken  = pr;
   endtask

   task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i, input logic pr);
      offer(t, a, b, p, i, pr);
      tick();
      bif.in_valid = 1'b0;
   endtask

   task automatic peek(input logic [31:0] lpc, input logic exp, input string tag);
      bif.lookup_pc = lpc;
      #1;
      check(tag, 64'(bif.lookup_taken), 64'(exp));
   endtask

   initial begin
      rst = 1'b1;
      bif.in_valid = 1'b0; bif.branch_type = 3'd0; bif.rs1_data = '0; bif.rs2_data = '0;
      bif.pc = '0; bif.imm = '0; bif.pred_taken = 1'b0; bif.flush = 1'b0;
      bif.lookup_pc = '0; bif.out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;

      check("rst_out_valid", 64'(bif.out_valid), 64'd0);
      check("rst_taken", 64'(bif.taken), 64'd0);
      check("rst_target", 64'(bif.target), 64'd0);
      check("rst_mispredict", 64'(bif.mispredict), 64'd0);
      check("rst_redirect", 64'(bif.redirect_pc), 64'd0);
      check("rst_cnt", 64'(bif.mispredict_cnt), 64'd0);
      check("rst_in_ready", 64'(bif.in_ready), 64'd1);
      peek(32'h40, 1'b0, "rst_lookup");

      // BEQ equal, predicted not-taken: held one cycle so the count lands on handshake.
      bif.out_ready = 1'b0;
      issue(3'd1, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
      check("beq_valid", 64'(bif.out_valid), 64'd1);
      check("beq_taken", 64'(bif.taken), 64'd1);
      check("beq_target", 64'(bif.target), 64'h120);
      check("beq_mispredict", 64'(bif.mispredict), 64'd1);
      check("beq_redirect", 64'(bif.redirect_pc), 64'h120);
      check("beq_cnt_before", 64'(bif.mispredict_cnt), 64'd0);
      bif.out_ready = 1'b1;
      tick();
      check("beq_cnt_after", 64'(bif.mispredict_cnt), 64'd1);
      check("beq_popped", 64'(bif.out_valid), 64'd0);

      issue(3'd4, 32'h7, 32'h7, 32'h104, 32'h10, 1'b1);
      check("bge_taken", 64'(bif.taken), 64'd1);
      check("bge_mispredict", 64'(bif.mispredict), 64'd0);
      check("bge_target", 64'(bif.target), 64'h114);
      issue(3'd3, 32'hFFFFFFFF, 32'd1, 32'h108, 32'hFFFFFFF0, 1'b0);
      check("blt_taken", 64'(bif.taken), 64'd1);
      check("blt_target", 64'(bif.target), 64'hF8);
      check("blt_redirect", 64'(bif.redirect_pc), 64'hF8);
      issue(3'd5, 32'hFFFFFFFF, 32'd1, 32'h10C, 32'h8, 1'b1);
      check("bltu_taken", 64'(bif.taken), 64'd0);
      check("bltu_mispredict", 64'(bif.mispredict), 64'd1);
      check("bltu_target", 64'(bif.target), 64'h114);
      check("bltu_redirect", 64'(bif.redirect_pc), 64'h110);
      issue(3'd6, 32'hFFFFFFFF, 32'd1, 32'h110, 32'h4, 1'b0);
      check("bgeu_taken", 64'(bif.taken), 64'd1);
      check("bgeu_redirect", 64'(bif.redirect_pc), 64'h114);
      issue(3'd2, 32'd3, 32'd3, 32'h114, 32'h40, 1'b0);
      check("bne_eq_taken", 64'(bif.taken), 64'd0);
      check("bne_eq_redirect", 64'(bif.redirect_pc), 64'h118);
      tick();
      check("cmp_cnt", 64'(bif.mispredict_cnt), 64'd4);

      issue(3'd1, 32'd1, 32'd1, 32'hFFFFFFFC, 32'h8, 1'b1);
      check("wrap_target", 64'(bif.target), 64'h4);
      check("wrap_redirect_t", 64'(bif.redirect_pc), 64'h4);
      issue(3'd2, 32'd1, 32'd1, 32'hFFFFFFFC, 32'h8, 1'b0);
      check("wrap_redirect_nt", 64'(bif.redirect_pc), 64'h0);
      check("wrap_taken_nt", 64'(bif.taken), 64'd0);

      // Train idx 6 to 2 so an unwanted decrement by type 7 would show.
      issue(3'd1, 32'd1, 32'd1, 32'h118, 32'h8, 1'b1);
      peek(32'h118, 1'b1, "t7_pre_lookup");
      issue(3'd7, 32'd1, 32'd1, 32'h118, 32'h8, 1'b1);
      check("t7_valid", 64'(bif.out_valid), 64'd1);
      check("t7_taken", 64'(bif.taken), 64'd0);
      check("t7_mispredict", 64'(bif.mispredict), 64'd0);
      peek(32'h118, 1'b1, "t7_bht_unchanged");
      tick();
      check("t7_cnt", 64'(bif.mispredict_cnt), 64'd4);

      bif.out_ready = 1'b0;
      issue(3'd1, 32'd2, 32'd2, 32'h11C, 32'h40, 1'b1);
      offer(3'd2, 32'd1, 32'd2, 32'h120, 32'h10, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_in_ready", 64'(bif.in_ready), 64'd0);
         check("bp_valid", 64'(bif.out_valid), 64'd1);
         check("bp_target", 64'(bif.target), 64'h15C);
         check("bp_taken", 64'(bif.taken), 64'd1);
         tick();
      end
      bif.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(bif.in_ready), 64'd1);
      tick();
      bif.in_valid = 1'b0;
      check("bp_second_valid", 64'(bif.out_valid), 64'd1);
      check("bp_second_target", 64'(bif.target), 64'h130);
      check("bp_second_mp", 64'(bif.mispredict), 64'd1);
      tick();
      check("bp_cnt", 64'(bif.mispredict_cnt), 64'd5);

      bif.out_ready = 1'b0;
      issue(3'd1, 32'd1, 32'd1, 32'h124, 32'h8, 1'b0);
      bif.flush = 1'b1;
      tick();
      check("flush_valid", 64'(bif.out_valid), 64'd0);
      check("flush_cnt", 64'(bif.mispredict_cnt), 64'd5);
      peek(32'h128, 1'b0, "flush_pre_lookup");
      offer(3'd1, 32'd3, 32'd3, 32'h128, 32'h8, 1'b0);
      tick();
      bif.in_valid = 1'b0;
      bif.flush = 1'b0;
      check("flush_op_dropped", 64'(bif.out_valid), 64'd0);
      peek(32'h128, 1'b1, "flush_op_trained");
      bif.out_ready = 1'b1;
      issue(3'd1, 32'd1, 32'd1, 32'h12C, 32'h8, 1'b0);
      bif.flush = 1'b1;
      tick();
      bif.flush = 1'b0;
      check("flush_hs_valid", 64'(bif.out_valid), 64'd0);
      check("flush_hs_cnt", 64'(bif.mispredict_cnt), 64'd6);

      peek(32'h40, 1'b1, "pre_reset_lookup");
      bif.out_ready = 1'b0;
      issue(3'd1, 32'd1, 32'd1, 32'h130, 32'h8, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bif.out_ready = 1'b1;
      check("mid_rst_valid", 64'(bif.out_valid), 64'd0);
      check("mid_rst_cnt", 64'(bif.mispredict_cnt), 64'd0);
      check("mid_rst_target", 64'(bif.target), 64'd0);
      peek(32'h40, 1'b0, "mid_rst_lookup");

      offer(3'd2, 32'd1, 32'd2, 32'h40, 32'h8, 1'b1);
      peek(32'h40, 1'b0, "bht_no_bypass");
      tick();
      peek(32'h40, 1'b1, "bht_t1");
      for (int k = 0; k < 3; k++) tick();
      bif.in_valid = 1'b0;
      peek(32'h40, 1'b1, "bht_t4");
      offer(3'd2, 32'd5, 32'd5, 32'h40, 32'h8, 1'b0);
      tick();
      peek(32'h40, 1'b1, "bht_nt1");
      tick();
      peek(32'h40, 1'b0, "bht_nt2");
      for (int k = 0; k < 3; k++) tick();
      peek(32'h40, 1'b0, "bht_nt5_floor");
      offer(3'd2, 32'd1, 32'd2, 32'h40, 32'h8, 1'b1);
      tick();
      peek(32'h40, 1'b0, "bht_up1");
      tick();
      bif.in_valid = 1'b0;
      peek(32'h40, 1'b1, "bht_up2");
      tick();
      check("bht_cnt", 64'(bif.mispredict_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
